// File: rtl/booth_seq_mul_ctrl.sv
// Sequential radix-4 Booth multiplier: a single carry-select adder is reused once per
// recoded multiplier digit, N/2 iterations per product, valid/ready on both sides.

module booth_csa #(
    parameter int W   = 24,
    parameter int BLK = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         carry_i,
    output logic [W-1:0] s_o,
    output logic         carry_o
);
    localparam int NB = W / BLK;

    logic [NB:0] c;

    assign c[0] = carry_i;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLK:0] r0;
        logic [BLK:0] r1;
        // Both carry-in cases are summed up front; the incoming block carry only selects.
        assign r0 = {1'b0, a_i[g*BLK +: BLK]} + {1'b0, b_i[g*BLK +: BLK]};
        assign r1 = {1'b0, a_i[g*BLK +: BLK]} + {1'b0, b_i[g*BLK +: BLK]} + (BLK+1)'(1);
        assign s_o[g*BLK +: BLK] = c[g] ? r1[BLK-1:0] : r0[BLK-1:0];
        assign c[g+1]            = c[g] ? r1[BLK]     : r0[BLK];
    end

    assign carry_o = c[NB];
endmodule

module booth_seq_mul_ctrl #(
    parameter int N       = 20,
    parameter int sizeRCA = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] P
);
    localparam int W  = N + 4;
    localparam int AW = 2 * N + 5;
    localparam int CW = $clog2(N / 2) + 1;

    if ((N % 2) != 0) begin : g_bad_n
        $error("booth_seq_mul_ctrl: N must be even");
    end
    if ((W % sizeRCA) != 0) begin : g_bad_rca
        $error("booth_seq_mul_ctrl: N+4 must be a multiple of sizeRCA");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d, acc_next;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  p_q, p_d;
    logic            live_q;
    logic [W-1:0]    addend;
    logic            add_cin;
    logic [W-1:0]    csa_sum;
    logic            csa_cout_unused;

    // Booth digit select; negative digits use ~multiple plus carry-in for two's complement.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        addend  = '0;
        add_cin = 1'b0;
        unique case (acc_q[2:0])
            3'b001, 3'b010: addend = mcand_q;
            3'b011:         addend = {mcand_q[W-2:0], 1'b0};
            3'b100: begin
                addend  = ~{mcand_q[W-2:0], 1'b0};
                add_cin = 1'b1;
            end
            3'b101, 3'b110: begin
                addend  = ~mcand_q;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    booth_csa #(.W(W), .BLK(sizeRCA)) u_csa (
        .a_i     (acc_q[AW-1:N+1]),
        .b_i     (addend),
        .carry_i (add_cin),
        .s_o     (csa_sum),
        .carry_o (csa_cout_unused)
    );

    // Guard bits above the product keep the arithmetic shift sign-correct.
    assign acc_next = AW'($signed({csa_sum, acc_q[N:0]}) >>> 2);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    mcand_d = {{4{A[N-1]}}, A};
                    acc_d   = {{W{1'b0}}, B, 1'b0};
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N / 2 - 1)) begin
                    p_d     = acc_next[2*N:1];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            live_q  <= 1'b1;
        end
    end

    // live_q holds in_ready low for the first cycle after reset is released.
    assign in_ready  = live_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign P         = p_q;
endmodule

// File: tb/tb_booth_seq_mul_ctrl.sv
// Directed and random checks of booth_seq_mul_ctrl: products, latency, handshake and reset.

module tb_booth_seq_mul_ctrl;
    localparam int N   = 20;
    localparam int LAT = N / 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   A = '0;
    logic [N-1:0]   B = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] P;

    int checks = 0;
    int errors = 0;

    booth_seq_mul_ctrl #(.N(N), .sizeRCA(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one operation and reports product, latency, stall stability and post-handshake state.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall,
                          input bit early, output logic [2*N-1:0] got, output int lat,
                          output bit stable_ok, output bit post_ok);
        int w;
        stable_ok = 1'b1;
        post_ok   = 1'b0;
        got       = 'x;
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (in_ready !== 1'b1) begin
            lat = -1;
            return;
        end
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = N'($urandom);
        B = N'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        got = P;
        if (!early) begin
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                if (out_valid !== 1'b1 || P !== got || in_ready !== 1'b0) stable_ok = 1'b0;
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        post_ok = (out_valid === 1'b0) && (in_ready === 1'b1) && (P === got);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || P !== '0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b P=%h, required 0 0 0",
                     in_ready, out_valid, P);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_same_cycle: in_ready=%b, required 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_next: in_ready=%b out_valid=%b, required 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0]   va [8] = '{20'h00000, 20'h00001, 20'h0003F, 20'hFFFFF,
                                   20'h80000, 20'h7FFFF, 20'h80000, 20'h7FFFF};
        logic [N-1:0]   vb [8] = '{20'h00000, 20'h00001, 20'h0003F, 20'h00005,
                                   20'h80000, 20'h80000, 20'h7FFFF, 20'h7FFFF};
        logic [2*N-1:0] vp [8] = '{40'h0000000000, 40'h0000000001, 40'h0000000F81,
                                   40'hFFFFFFFFFB, 40'h4000000000, 40'hC000080000,
                                   40'hC000080000, 40'h3FFFF00001};
        logic [2*N-1:0] got;
        int lat;
        bit st, po;
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], 0, 1'b0, got, lat, st, po);
            checks++;
            if (got !== vp[i]) begin
                errors++;
                $display("FAIL directed_product[%0d]: A=%h B=%h P=%h, required %h",
                         i, va[i], vb[i], got, vp[i]);
            end
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL directed_latency[%0d]: %0d cycles, required %0d", i, lat, LAT);
            end
            checks++;
            if (!po) begin
                errors++;
                $display("FAIL directed_return_idle[%0d]: out_valid=%b in_ready=%b, required 0 1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_stall();
        logic [2*N-1:0] got;
        int lat;
        bit st, po;
        run_op(20'hFFFFE, 20'hFFFFD, 5, 1'b0, got, lat, st, po);
        checks++;
        if (got !== 40'h0000000006) begin
            errors++;
            $display("FAIL stall_product: P=%h, required 0000000006", got);
        end
        checks++;
        if (!st) begin
            errors++;
            $display("FAIL stall_hold: out_valid/P/in_ready changed while out_ready low, required stable 1/6/0");
        end
        checks++;
        if (!po || lat != LAT) begin
            errors++;
            $display("FAIL stall_release: post_ok=%b lat=%0d, required 1 and %0d", po, lat, LAT);
        end
        // out_ready already high during BUSY must not shorten or skip DONE.
        run_op(20'h00009, 20'h00007, 0, 1'b1, got, lat, st, po);
        checks++;
        if (got !== 40'h000000003F || lat != LAT || !po) begin
            errors++;
            $display("FAIL early_out_ready: P=%h lat=%0d post_ok=%b, required 000000003F %0d 1",
                     got, lat, po, LAT);
        end
    endtask

    task automatic test_busy_in_valid();
        int cyc;
        bit idle_ok;
        in_valid = 1'b1;
        A = 20'h00100;
        B = 20'h00010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        A = 20'h00005;
        B = 20'h00005;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_ready: in_ready=%b during BUSY, required 0", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 4;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (P !== 40'h0000001000 || cyc != LAT) begin
            errors++;
            $display("FAIL busy_ignore_product: P=%h lat=%0d, required 0000001000 %0d", P, cyc, LAT);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        idle_ok = 1'b1;
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) idle_ok = 1'b0;
        end
        checks++;
        if (!idle_ok) begin
            errors++;
            $display("FAIL busy_not_queued: a second product appeared, required none");
        end
    endtask

    task automatic test_reset_mid();
        logic [2*N-1:0] got;
        int lat;
        bit st, po;
        run_op(20'h00003, 20'h00005, 0, 1'b0, got, lat, st, po);
        checks++;
        if (got !== 40'h000000000F) begin
            errors++;
            $display("FAIL pre_reset_product: P=%h, required 000000000F", got);
        end
        in_valid = 1'b1;
        A = 20'h00064;
        B = 20'h00064;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || P !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: out_valid=%b P=%h in_ready=%b, required 0 0 0",
                     out_valid, P, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_recover: in_ready=%b out_valid=%b, required 1 0",
                     in_ready, out_valid);
        end
        run_op(20'h00007, 20'hFFFFD, 0, 1'b0, got, lat, st, po);
        checks++;
        if (got !== 40'hFFFFFFFFEB || lat != LAT) begin
            errors++;
            $display("FAIL post_reset_product: P=%h lat=%0d, required FFFFFFFFEB %0d", got, lat, LAT);
        end
    endtask

    task automatic test_random();
        logic [N-1:0]          a, b;
        logic signed [2*N-1:0] exp_p;
        logic [2*N-1:0]        got;
        int lat;
        bit st, po;
        for (int i = 0; i < 1000; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            exp_p = $signed(a) * $signed(b);
            run_op(a, b, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), got, lat, st, po);
            checks++;
            if (got !== exp_p || lat != LAT || !st || !po) begin
                errors++;
                $display("FAIL random[%0d]: A=%h B=%h P=%h lat=%0d stable=%b post=%b, required P=%h lat=%0d 1 1",
                         i, a, b, got, lat, st, po, exp_p, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_busy_in_valid();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
